muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit for the MIPS execute stage. Successor to the single-cycle ALU.
- Implements MULT, MULTU, DIV and DIVU over WIDTH-bit operands, one radix-2 step per cycle.
- Owns the architectural HI/LO registers and supports MTHI/MTLO writes.
- Uses a start/busy/done handshake so the pipeline can stall on MFHI/MFLO while busy.

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared execute-stage types: multiply/divide opcodes, FSM states, latency.
package cpu_types_pkg;

    localparam int WORD_W         = 32;
    // Edges from the start sample to the edge that raises done.
    localparam int MULDIV_LATENCY = WORD_W + 1;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Signed ops run on magnitudes; signs are reapplied in FIX.
// Optional MULDIV_DIVZ_EN adds a sticky divide-by-zero flag port (divz).
module muldiv_unit
    import cpu_types_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] portA,
    input  logic [WIDTH-1:0] portB,
    input  logic             abort,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdat,
    output logic             busy,
    output logic             done,
`ifdef MULDIV_DIVZ_EN
    output logic             divz,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    muldiv_state_t    state, state_n;
    muldiv_op_t       op_e;
    logic [CNTW-1:0]  cnt;
    logic             is_div_q, sign_q, rsign_q, bz_q;
    logic [WIDTH-1:0] opnd_q, araw_q, acc_hi, acc_lo;
    logic             launch;

    logic             in_signed, in_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    logic [WIDTH-1:0] step_hi, step_lo, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod;

    assign op_e   = muldiv_op_t'(op);
    assign launch = (state == IDLE) && start && !abort;
    assign busy   = (state != IDLE);

    // Operand magnitudes and sign bits for the incoming request
    always_comb begin
        in_signed = (op_e == MD_MULT) || (op_e == MD_DIV);
        in_div    = (op_e == MD_DIV)  || (op_e == MD_DIVU);
        a_neg     = in_signed & portA[WIDTH-1];
        b_neg     = in_signed & portB[WIDTH-1];
        a_mag     = a_neg ? (~portA + 1'b1) : portA;
        b_mag     = b_neg ? (~portB + 1'b1) : portB;
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
        div_sh   = {acc_hi, acc_lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_sh[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            {step_hi, step_lo} = {mul_sum, acc_lo[WIDTH-1:1]};
        end
    end

    // Sign fix-up; divide-by-zero bypasses it and returns the raw dividend
    always_comb begin
        prod = {acc_hi, acc_lo};
        if (!is_div_q) begin
            {fix_hi, fix_lo} = sign_q ? (~prod + 1'b1) : prod;
        end else if (bz_q) begin
            fix_hi = araw_q;
            fix_lo = '1;
        end else begin
            fix_lo = sign_q  ? (~acc_lo + 1'b1) : acc_lo;
            fix_hi = rsign_q ? (~acc_hi + 1'b1) : acc_hi;
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    // FSM next state; abort wins over everything
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (launch) state_n = CALC;
            CALC:    if (cnt == CNTW'(1)) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    // Operand latch on launch, then one accumulator step per CALC cycle
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd_q   <= '0;
            araw_q   <= '0;
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            rsign_q  <= 1'b0;
            bz_q     <= 1'b0;
        end else if (launch) begin
            cnt      <= CNTW'(WIDTH);
            acc_hi   <= '0;
            acc_lo   <= a_mag;
            opnd_q   <= b_mag;
            araw_q   <= portA;
            is_div_q <= in_div;
            sign_q   <= a_neg ^ b_neg;
            rsign_q  <= a_neg;
            bz_q     <= (portB == '0);
        end else if (state == CALC && !abort) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt - 1'b1;
        end
    end

    // HI/LO: result write in FIX, otherwise MTHI/MTLO while idle
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == FIX) && !abort;
            if (state == FIX && !abort) begin
                hi <= fix_hi;
                lo <= fix_lo;
            end else if (!busy) begin
                if (hi_we) hi <= wdat;
                if (lo_we) lo <= wdat;
            end
        end
    end

`ifdef MULDIV_DIVZ_EN
    // Sticky divide-by-zero flag, reset by each new operation
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                                            divz <= 1'b0;
        else if (launch)                                      divz <= 1'b0;
        else if (state == FIX && !abort && is_div_q && bz_q) divz <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected HI/LO, monitor checks on done.
module tb_muldiv_unit;
    import cpu_types_pkg::*;

    localparam int W = 32;

    logic         CLK = 1'b0, nRST = 1'b0;
    logic         start = 1'b0, abort = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] portA = '0, portB = '0, wdat = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;
`ifdef MULDIV_DIVZ_EN
    logic         divz;
`endif

    muldiv_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .op(op),
        .portA(portA), .portB(portB), .abort(abort),
        .hi_we(hi_we), .lo_we(lo_we), .wdat(wdat),
        .busy(busy), .done(done),
`ifdef MULDIV_DIVZ_EN
        .divz(divz),
`endif
        .hi(hi), .lo(lo)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   n_chk = 0, n_pass = 0;
    int   cyc = 0, start_edge = 0, done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, req);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest expected result
    always @(negedge CLK) begin
        if (nRST && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_done", {63'd0, done}, 64'd0);
            end else begin
                m_e = exp_q.pop_front();
                check("hi", {32'd0, hi}, {32'd0, m_e.hi});
                check("lo", {32'd0, lo}, {32'd0, m_e.lo});
                check("latency", 64'(cyc - start_edge), 64'(MULDIV_LATENCY));
`ifdef MULDIV_DIVZ_EN
                check("divz", {63'd0, divz}, {63'd0, m_e.dz});
`endif
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic push, input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic dz);
        exp_t e;
        e.hi = eh; e.lo = el; e.dz = dz;
        if (push) exp_q.push_back(e);
        @(negedge CLK);
        op = o; portA = a; portB = b; start = 1'b1;
        @(posedge CLK);
        #1 start_edge = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < 100) begin
            @(posedge CLK);
            #2 k++;
        end
        if (k >= 100) check("done_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic dz);
        issue(o, a, b, 1'b1, eh, el, dz);
        wait_done();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_hi",   {32'd0, hi}, 64'd0);
        check("rst_lo",   {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        nRST = 1'b1;

        // MTLO / MTHI while idle
        @(negedge CLK); lo_we = 1'b1; wdat = 32'h0000_AAAA;
        @(negedge CLK); lo_we = 1'b0; hi_we = 1'b1; wdat = 32'h0000_5555;
        @(negedge CLK); hi_we = 1'b0;
        check("mtlo", {32'd0, lo}, 64'h0000_AAAA);
        check("mthi", {32'd0, hi}, 64'h0000_5555);

        // MULT 5*5 aborted at cycle 10: no done, HI/LO keep MTHI/MTLO values
        issue(MD_MULT, 32'd5, 32'd5, 1'b0, '0, '0, 1'b0);
        repeat (10) @(negedge CLK);
        check("busy_before_abort", {63'd0, busy}, 64'd1);
        abort = 1'b1;
        @(negedge CLK); abort = 1'b0;
        check("busy_after_abort", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge CLK);
        check("abort_lo", {32'd0, lo}, 64'h0000_AAAA);
        check("abort_hi", {32'd0, hi}, 64'h0000_5555);

        // abort beats start in the same cycle
        @(negedge CLK); op = MD_MULTU; portA = 32'd3; portB = 32'd3; start = 1'b1; abort = 1'b1;
        @(negedge CLK); start = 1'b0; abort = 1'b0;
        check("abort_over_start", {63'd0, busy}, 64'd0);

        // Directed arithmetic vectors
        run(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run(MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run(MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run(MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run(MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run(MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
        run(MD_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        run(MD_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        run(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);

        // start and MTLO during busy are both ignored
        issue(MD_MULTU, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, 1'b0);
        repeat (4) @(negedge CLK);
        op = MD_DIVU; portA = 32'd9; portB = 32'd0; start = 1'b1; lo_we = 1'b1; wdat = 32'hDEAD;
        @(negedge CLK); start = 1'b0; lo_we = 1'b0;
        wait_done();
        repeat (40) @(negedge CLK);

        // Asynchronous reset in the middle of a DIVU
        issue(MD_DIVU, 32'd1000, 32'd3, 1'b0, '0, '0, 1'b0);
        repeat (14) @(negedge CLK);
        #1 nRST = 1'b0;
        #1;
        check("arst_hi",   {32'd0, hi}, 64'd0);
        check("arst_lo",   {32'd0, lo}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        @(negedge CLK); nRST = 1'b1;
        run(MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        repeat (5) @(negedge CLK);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
